// File: rtl/keyboard_pkg.sv
// Shared constants and types for the buffered PS/2-style keyboard controller.
// Holds the scan-code values the decoder reacts to, the set-LEDs command
// byte sent to the keyboard, and the LED command sequencer state type.
package keyboard_pkg;

    localparam logic [7:0] SC_EXTENDED      = 8'hE0;
    localparam logic [7:0] SC_RELEASE       = 8'hF0;
    localparam logic [7:0] SC_CAPS_LOCK     = 8'h58;
    localparam logic [7:0] SC_NUM_LOCK      = 8'h77;
    localparam logic [7:0] SC_SCROLL_LOCK   = 8'h7E;
    localparam logic [7:0] SC_BAT_OK        = 8'hAA;
    localparam logic [7:0] SC_KBD_ACK       = 8'hFA;
    localparam logic [7:0] SC_LSHIFT        = 8'h12;
    localparam logic [7:0] SC_RSHIFT        = 8'h59;
    localparam logic [7:0] SC_CTRL          = 8'h14;
    localparam logic [7:0] SC_ALT           = 8'h11;

    localparam logic [7:0] COMMAND_SET_LEDS = 8'hED;

    // {caps, num, scroll}: num lock on after reset
    localparam logic [2:0] LEDS_RESET       = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        CMD_ACK,
        CMD_KBD,
        DATA,
        DATA_ACK,
        DATA_KBD
    } led_state_e;

endpackage

// File: rtl/keyboard_fifo.sv
// First-word-fall-through byte FIFO.
// Ports:
//   clk, reset_low     clock, synchronous active-low reset
//   push, push_data    write request and byte
//   pop                read request (head advances when not empty)
//   dout               head entry, valid while empty = 0
//   empty              no entries held
//   free               number of unused entries (DEPTH - count)
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module keyboard_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_low,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != DEPTH_C) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count_q gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign free  = DEPTH_C - count_q;

endmodule

// File: rtl/keyboard_buffered.sv
// Buffered keyboard controller: decodes received scan bytes, tracks lock LEDs
// and modifier keys, queues character codes in a FIFO, and sends the
// set-LEDs command to the keyboard whenever lock state must be refreshed.
// Ports:
//   clk, reset_low                              clock, synchronous active-low reset
//   command_{ready,valid,byte}                  host-to-keyboard byte handshake
//   command_ack_{ready,valid,error}             transmit completion status
//   scan_code_{ready,valid,byte}                received keyboard bytes
//   character_{ready,valid,byte}                FIFO output
//   leds {caps,num,scroll}, modifiers {ctrl,alt,shift}, overflow, led_error
//
// LED sequencer states:
//   state    | meaning
//   IDLE     | waiting for a pending LED request
//   CMD      | offering 8'hED to the transmitter
//   CMD_ACK  | waiting for transmit status of 8'hED
//   CMD_KBD  | waiting for keyboard 8'hFA after 8'hED
//   DATA     | offering LED byte to the transmitter
//   DATA_ACK | waiting for transmit status of LED byte
//   DATA_KBD | waiting for keyboard 8'hFA after LED byte
module keyboard_buffered
    import keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int ACK_TIMEOUT  = 1000000,
    parameter int MAX_RETRIES  = 3,
    parameter int EMIT_RELEASE = 0
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       command_ready,
    output logic       command_valid,
    output logic [7:0] command_byte,
    output logic       command_ack_ready,
    input  logic       command_ack_valid,
    input  logic       command_ack_error,
    output logic       scan_code_ready,
    input  logic       scan_code_valid,
    input  logic [7:0] scan_code_byte,
    input  logic       character_ready,
    output logic       character_valid,
    output logic [7:0] character_byte,
    output logic [2:0] leds,
    output logic [2:0] modifiers,
    output logic       overflow,
    output logic       led_error
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

    localparam int K_RSHIFT = 0;
    localparam int K_LSHIFT = 1;
    localparam int K_RALT   = 2;
    localparam int K_LALT   = 3;
    localparam int K_RCTRL  = 4;
    localparam int K_LCTRL  = 5;

    led_state_e    state_q, state_d;
    logic          extended_q, extended_d;
    logic          released_q, released_d;
    logic [5:0]    keys_q, keys_d;
    logic [2:0]    leds_q, leds_d;
    logic          overflow_q, overflow_d;
    logic          pending_q, pending_d;
    logic [RW-1:0] retries_q, retries_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          led_error_q, led_error_d;
    logic [23:0]   stage_q, stage_d;
    logic [1:0]    stage_cnt_q, stage_cnt_d;

    logic          led_req, kbd_ack, is_lock, grp_accept, fail;
    logic [1:0]    grp_len, cnt_v;
    logic [23:0]   grp_v, stage_v;
    logic [CW-1:0] fifo_free, avail;
    logic          fifo_empty;

    assign is_lock = (scan_code_byte == SC_CAPS_LOCK) || (scan_code_byte == SC_NUM_LOCK) ||
                     (scan_code_byte == SC_SCROLL_LOCK);

    // Scan-code decoder. Group bytes are packed with the first byte in [7:0].
    always_comb begin
        extended_d = extended_q;
        released_d = released_q;
        keys_d     = keys_q;
        leds_d     = leds_q;
        led_req    = 1'b0;
        kbd_ack    = 1'b0;
        grp_len    = 2'd0;
        grp_v      = '0;
        if (scan_code_valid) begin
            if (scan_code_byte == SC_EXTENDED) begin
                extended_d = 1'b1;
            end else if (scan_code_byte == SC_RELEASE) begin
                released_d = 1'b1;
            end else begin
                extended_d = 1'b0;
                released_d = 1'b0;
                if (!extended_q && is_lock) begin
                    if (!released_q) begin
                        led_req = 1'b1;
                        if (scan_code_byte == SC_CAPS_LOCK)      leds_d[2] = ~leds_q[2];
                        else if (scan_code_byte == SC_NUM_LOCK)  leds_d[1] = ~leds_q[1];
                        else                                     leds_d[0] = ~leds_q[0];
                    end
                end else if (!extended_q && scan_code_byte == SC_BAT_OK) begin
                    led_req = 1'b1;
                end else if (!extended_q && scan_code_byte == SC_KBD_ACK) begin
                    kbd_ack = 1'b1;
                end else if (scan_code_byte == SC_LSHIFT) begin
                    keys_d[K_LSHIFT] = !released_q;
                end else if (scan_code_byte == SC_RSHIFT) begin
                    keys_d[K_RSHIFT] = !released_q;
                end else if (scan_code_byte == SC_CTRL) begin
                    keys_d[extended_q ? K_RCTRL : K_LCTRL] = !released_q;
                end else if (scan_code_byte == SC_ALT) begin
                    keys_d[extended_q ? K_RALT : K_LALT] = !released_q;
                end else if (!released_q) begin
                    grp_len = extended_q ? 2'd2 : 2'd1;
                    grp_v   = extended_q ? {8'h00, scan_code_byte, SC_EXTENDED}
                                         : {16'h0000, scan_code_byte};
                end else if (EMIT_RELEASE != 0) begin
                    grp_len = extended_q ? 2'd3 : 2'd2;
                    grp_v   = extended_q ? {scan_code_byte, SC_RELEASE, SC_EXTENDED}
                                         : {8'h00, scan_code_byte, SC_RELEASE};
                end
            end
        end
    end

    // Space already promised to staged bytes is not available to a new group,
    // so a group either fits completely or is dropped completely.
    always_comb begin
        avail      = fifo_free - CW'(stage_cnt_q);
        grp_accept = (grp_len != 2'd0) && (avail >= CW'(grp_len));
        overflow_d = overflow_q || ((grp_len != 2'd0) && !grp_accept);
    end

    // Staging buffer feeds the FIFO one byte per cycle. Output bytes never
    // outnumber input bytes, so three entries cannot overrun.
    always_comb begin
        stage_v = stage_q;
        cnt_v   = stage_cnt_q;
        if (stage_cnt_q != 2'd0) begin
            stage_v = {8'h00, stage_q[23:8]};
            cnt_v   = stage_cnt_q - 2'd1;
        end
        stage_d     = stage_v;
        stage_cnt_d = cnt_v;
        if (grp_accept) begin
            stage_d     = stage_v | (grp_v << {cnt_v, 3'b000});
            stage_cnt_d = cnt_v + grp_len;
        end
    end

    keyboard_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_low (reset_low),
        .push      (stage_cnt_q != 2'd0),
        .push_data (stage_q[7:0]),
        .pop       (character_ready),
        .dout      (character_byte),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    // LED command sequencer
    always_comb begin
        state_d           = state_q;
        pending_d         = pending_q || led_req;
        retries_d         = retries_q;
        timer_d           = timer_q;
        led_error_d       = led_error_q;
        command_valid     = 1'b0;
        command_byte      = 8'h00;
        command_ack_ready = 1'b0;
        fail              = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = CMD;
                    pending_d = led_req;
                    retries_d = '0;
                end
            end
            CMD: begin
                command_valid = 1'b1;
                command_byte  = COMMAND_SET_LEDS;
                if (command_ready) state_d = CMD_ACK;
            end
            CMD_ACK: begin
                command_ack_ready = 1'b1;
                if (command_ack_valid) begin
                    if (command_ack_error) begin
                        fail = 1'b1;
                    end else begin
                        state_d = CMD_KBD;
                        timer_d = TW'(ACK_TIMEOUT - 1);
                    end
                end
            end
            CMD_KBD: begin
                if (kbd_ack)               state_d = DATA;
                else if (timer_q == '0)    fail    = 1'b1;
                else                       timer_d = timer_q - TW'(1);
            end
            DATA: begin
                command_valid = 1'b1;
                command_byte  = {5'b00000, leds_q};
                if (command_ready) state_d = DATA_ACK;
            end
            DATA_ACK: begin
                command_ack_ready = 1'b1;
                if (command_ack_valid) begin
                    if (command_ack_error) begin
                        fail = 1'b1;
                    end else begin
                        state_d = DATA_KBD;
                        timer_d = TW'(ACK_TIMEOUT - 1);
                    end
                end
            end
            DATA_KBD: begin
                if (kbd_ack)               state_d = IDLE;
                else if (timer_q == '0)    fail    = 1'b1;
                else                       timer_d = timer_q - TW'(1);
            end
            default: state_d = IDLE;
        endcase
        // Any failure restarts from the command byte.
        if (fail) begin
            if (retries_q < RW'(MAX_RETRIES)) begin
                state_d   = CMD;
                retries_d = retries_q + RW'(1);
            end else begin
                state_d     = IDLE;
                led_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            state_q     <= IDLE;
            extended_q  <= 1'b0;
            released_q  <= 1'b0;
            keys_q      <= '0;
            leds_q      <= LEDS_RESET;
            overflow_q  <= 1'b0;
            pending_q   <= 1'b0;
            retries_q   <= '0;
            timer_q     <= '0;
            led_error_q <= 1'b0;
            stage_q     <= '0;
            stage_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            extended_q  <= extended_d;
            released_q  <= released_d;
            keys_q      <= keys_d;
            leds_q      <= leds_d;
            overflow_q  <= overflow_d;
            pending_q   <= pending_d;
            retries_q   <= retries_d;
            timer_q     <= timer_d;
            led_error_q <= led_error_d;
            stage_q     <= stage_d;
            stage_cnt_q <= stage_cnt_d;
        end
    end

    assign scan_code_ready = 1'b1;
    assign character_valid = !fifo_empty;
    assign leds            = leds_q;
    assign modifiers       = {keys_q[K_LCTRL] | keys_q[K_RCTRL],
                              keys_q[K_LALT]  | keys_q[K_RALT],
                              keys_q[K_LSHIFT] | keys_q[K_RSHIFT]};
    assign overflow        = overflow_q;
    assign led_error       = led_error_q;

endmodule

// File: doc/keyboard_buffered.md
KEYBOARD_BUFFERED -- requirements
Module: keyboard_buffered

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: character FIFO entries, power of two, at least 2.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1000000: clk cycles to wait for keyboard 8'hFA.
REQ-003 SHALL have parameter MAX_RETRIES, default 3: LED-command retries after the first attempt.
REQ-004 SHALL have parameter EMIT_RELEASE, default 0: 1 emits 8'hF0 plus code on key release.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on posedge.
REQ-006 SHALL have port reset_low, input, 1: synchronous, active-low reset.
REQ-007 SHALL have ports command_ready in 1, command_valid out 1, command_byte out 8: host-to-keyboard byte handshake.
REQ-008 SHALL have ports command_ack_ready out 1, command_ack_valid in 1, command_ack_error in 1: transmit completion status.
REQ-009 SHALL have ports scan_code_ready out 1, scan_code_valid in 1, scan_code_byte in 8: received bytes.
REQ-010 SHALL have ports character_ready in 1, character_valid out 1, character_byte out 8: FIFO output.
REQ-011 SHALL have ports leds out 3 {caps,num,scroll}, modifiers out 3 {ctrl,alt,shift}, overflow out 1, led_error out 1.

Function
REQ-012 A transfer SHALL occur when valid and ready are both high on a clk edge.
REQ-013 scan_code_ready SHALL be constantly 1; the FIFO absorbs bursts.
REQ-014 Decode: 8'hE0 sets extended; 8'hF0 sets released; any other byte clears both after it is processed.
REQ-015 Non-extended press of 58/77/7E SHALL toggle caps/num/scroll and raise an LED request; releases do not toggle.
REQ-016 Non-extended 8'hAA SHALL raise an LED request and leave lock states unchanged; non-extended 8'hFA SHALL pulse an internal keyboard-ack.
REQ-017 Modifiers: shift set by 12/59 press and cleared on release; ctrl by 14 (normal or extended); alt by 11 (normal or extended). modifiers SHALL be the OR of left and right keys.
REQ-018 Other presses SHALL push [E0,] code; releases with EMIT_RELEASE=1 SHALL push [E0,] F0, code; the whole group is pushed atomically across consecutive cycles.
REQ-019 If free entries are fewer than the group size when the final byte arrives, the group SHALL be dropped entirely and overflow set sticky.
REQ-020 FIFO SHALL be first-word-fall-through: character_valid = not empty, character_byte = head entry.
REQ-021 Simultaneous push and pop SHALL both occur; a full FIFO accepts a push on the same cycle as a pop.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be clog2(FIFO_DEPTH)+1 bits wide.
REQ-023 LED FSM states: IDLE, CMD, CMD_ACK, CMD_KBD, DATA, DATA_ACK, DATA_KBD.
REQ-024 IDLE to CMD SHALL occur when a request is pending; this clears the pending request.
REQ-025 CMD SHALL drive valid and 8'hED; DATA SHALL drive valid and {5'b0, leds} sampled that cycle. Each state advances on ready.
REQ-026 *_ACK states SHALL hold command_ack_ready high. ack_valid with no error advances; ack_valid with error is a failure.
REQ-027 *_KBD states SHALL advance on keyboard-ack (DATA_KBD goes to IDLE); a counter reaching ACK_TIMEOUT is a failure.
REQ-028 On failure, retries < MAX_RETRIES SHALL go to CMD with retries+1; otherwise go to IDLE and set led_error sticky.
REQ-029 A request raised during a transaction SHALL set pending, and one more transaction SHALL run after IDLE; requests coalesce.
REQ-030 A keyboard-ack outside *_KBD states SHALL be discarded.

Reset
REQ-031 While reset_low = 0 at a clk edge: FIFO empty; state IDLE; extended, released, pending, retries, timer, overflow, led_error = 0.
REQ-032 Reset values: leds = 3'b010 (num on); modifiers = 0; command_valid = 0; command_ack_ready = 0; scan_code_ready = 1.
REQ-033 Reset mid-transaction or mid-group SHALL abandon it without emitting a partial byte afterwards.

Structure
REQ-034 Package keyboard_pkg SHALL hold the scan-code constants, COMMAND_SET_LEDS, and the LED state enum.
REQ-035 The FIFO SHALL be sub-module keyboard_fifo, parametrised by depth, width 8, and exposing a free count.

Verification
REQ-036 Test: press 1C, release F0 1C with EMIT_RELEASE=0 -> one character 8'h1C only.
REQ-037 Test: E0 75 with EMIT_RELEASE=1, then E0 F0 75 -> characters E0,75,E0,F0,75.
REQ-038 Test: FIFO_DEPTH=8, character_ready=0, send 9 presses -> 8 held, overflow=1; then drain 8 in order.
REQ-039 Test: 58 press -> leds=3'b110; command bytes ED then 06, with FA returned after each ack -> IDLE.
REQ-040 Test: ack_error on ED four times with MAX_RETRIES=3 -> four ED attempts, led_error=1, IDLE.
REQ-041 Test: no FA within ACK_TIMEOUT=16 -> retry ED at cycle 16; reset_low=0 mid-DATA -> command_valid=0 next cycle.
